// File: rtl/led_pkg.sv
// Shared mode encodings and command record for the RGB LED pattern driver.
package led_pkg;

    localparam int unsigned PWM_W = 8;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SOLID   = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       rgb;
        logic [PWM_W-1:0] level;
    } led_cmd_t;

endpackage

// File: rtl/led_envelope.sv
// Blink phase and breathe envelope generator; produces the effective PWM level
// for the currently applied mode. Restart re-arms phase and envelope.
module led_envelope
    import led_pkg::*;
#(
    parameter int unsigned BLINK_TICKS = 20000000,
    parameter int unsigned STEP_TICKS  = 39062
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_restart,
    input  logic [1:0]       i_mode,
    input  logic [PWM_W-1:0] i_level,
    output logic [PWM_W-1:0] o_eff
);

    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned STEP_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase_on;
    logic [STEP_W-1:0]  r_step_cnt;
    logic [PWM_W-1:0]   r_breathe;
    logic               r_falling;

    logic w_blink_tc;
    logic w_step_tc;

    assign w_blink_tc = (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1));
    assign w_step_tc  = (r_step_cnt == STEP_W'(STEP_TICKS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
            r_step_cnt  <= '0;
            r_breathe   <= '0;
            r_falling   <= 1'b0;
        end else begin
            if (i_mode == MODE_BLINK) begin
                if (w_blink_tc) begin
                    r_blink_cnt <= '0;
                    r_phase_on  <= ~r_phase_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                end
            end
            if (i_mode == MODE_BREATHE) begin
                if (w_step_tc) begin
                    r_step_cnt <= '0;
                    // Envelope is clamped to [0, level]; a zero peak holds it at 0.
                    if (!r_falling) begin
                        if (r_breathe < i_level) begin
                            r_breathe <= r_breathe + 8'd1;
                            if ((r_breathe + 8'd1) == i_level) begin
                                r_falling <= 1'b1;
                            end
                        end
                    end else begin
                        if (r_breathe != '0) begin
                            r_breathe <= r_breathe - 8'd1;
                        end
                        if (r_breathe <= 8'd1) begin
                            r_falling <= 1'b0;
                        end
                    end
                end else begin
                    r_step_cnt <= r_step_cnt + STEP_W'(1);
                end
            end
        end
    end

    always_comb begin
        o_eff = '0;
        unique case (i_mode)
            MODE_OFF:     o_eff = '0;
            MODE_SOLID:   o_eff = i_level;
            MODE_BLINK:   o_eff = r_phase_on ? i_level : '0;
            MODE_BREATHE: o_eff = r_breathe;
            default:      o_eff = '0;
        endcase
    end

endmodule

// File: rtl/led_pattern_driver.sv
// RGB LED output stage: command handshake, period-aligned command apply,
// 8-bit PWM comparators and registered LED pins.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int unsigned BLINK_TICKS    = 20000000,
    parameter int unsigned STEP_TICKS     = 39062,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_rgb,
    input  logic [PWM_W-1:0] cmd_level,
    output logic             redled,
    output logic             greenled,
    output logic             blueled,
    output logic [1:0]       mode_o
);

    led_cmd_t         r_shadow;
    led_cmd_t         r_active;
    logic             r_pending;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [2:0]       r_pins;

    logic             w_accept;
    logic             w_apply;
    logic             w_on;
    logic [PWM_W-1:0] w_eff;

    assign cmd_ready = ~r_pending;
    assign w_accept  = cmd_valid & ~r_pending;
    // Only swap settings on the 255->0 edge so a PWM period is never cut short.
    assign w_apply   = r_pending & (r_pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_accept) begin
                r_shadow.mode  <= cmd_mode;
                r_shadow.rgb   <= cmd_rgb;
                r_shadow.level <= cmd_level;
                r_pending      <= 1'b1;
            end else if (w_apply) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

    led_envelope #(
        .BLINK_TICKS (BLINK_TICKS),
        .STEP_TICKS  (STEP_TICKS)
    ) u_envelope (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_restart (w_apply),
        .i_mode    (r_active.mode),
        .i_level   (r_active.level),
        .o_eff     (w_eff)
    );

    assign w_on = (w_eff == '1) || (r_pwm_cnt < w_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pins <= {3{LED_ACTIVE_LOW}};
        end else begin
            r_pins <= (r_active.rgb & {3{w_on}}) ^ {3{LED_ACTIVE_LOW}};
        end
    end

    assign redled   = r_pins[2];
    assign greenled = r_pins[1];
    assign blueled  = r_pins[0];
    assign mode_o   = r_active.mode;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with short blink/breathe timings.
module tb_led_pattern_driver;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_rgb;
    logic [7:0] cmd_level;
    logic       redled;
    logic       greenled;
    logic       blueled;
    logic [1:0] mode_o;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pwm_m = 8'd0;

    always #5 clk = ~clk;

    led_pattern_driver #(
        .BLINK_TICKS    (8),
        .STEP_TICKS     (2),
        .LED_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_rgb   (cmd_rgb),
        .cmd_level (cmd_level),
        .redled    (redled),
        .greenled  (greenled),
        .blueled   (blueled),
        .mode_o    (mode_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; pwm_m tracks the DUT's free-running PWM counter.
    task automatic tick();
        @(posedge clk);
        pwm_m = rst ? 8'd0 : pwm_m + 8'd1;
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [2:0] rgb, input logic [7:0] lvl);
        int n = 0;
        cmd_mode  = m;
        cmd_rgb   = rgb;
        cmd_level = lvl;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 600) begin
            tick();
            n++;
        end
        check_eq("send_ready_seen", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_eq("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic wait_apply(input logic [1:0] m);
        int n = 0;
        do begin
            tick();
            n++;
        end while (pwm_m != 8'd0 && n < 600);
        check_eq("apply_mode", {30'd0, mode_o}, {30'd0, m});
    endtask

    // One full PWM period from the apply edge; returns lit count on mask and bad samples.
    task automatic scan(input logic [2:0] mask, input logic [7:0] eff,
                        output int lit_cnt, output int bad);
        lit_cnt = 0;
        bad     = 0;
        for (int k = 0; k < 256; k++) begin
            logic [2:0] got;
            logic [2:0] exp;
            tick();
            got = ~{redled, greenled, blueled};
            exp = ((eff == 8'hFF) || (k < int'(eff))) ? mask : 3'b000;
            if (got != exp) bad++;
            if (got == mask) lit_cnt++;
        end
    endtask

    initial begin
        int lit;
        int bad;
        int n;
        int exp_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_rgb   = 3'd0;
        cmd_level = 8'd0;
        repeat (4) tick();
        rst = 1'b0;
        check_eq("reset_pins", {29'd0, redled, greenled, blueled}, 32'h7);
        check_eq("reset_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("reset_mode", {30'd0, mode_o}, 32'd0);
        tick();
        check_eq("idle_pins", {29'd0, redled, greenled, blueled}, 32'h7);

        // SOLID green at 64/256 duty.
        send(MODE_SOLID, 3'b010, 8'd64);
        wait_apply(MODE_SOLID);
        scan(3'b010, 8'd64, lit, bad);
        check_eq("solid64_lit_count", lit, 64);
        check_eq("solid64_shape", bad, 0);

        // Full scale is 100 %, then zero is fully dark.
        send(MODE_SOLID, 3'b100, 8'd255);
        wait_apply(MODE_SOLID);
        scan(3'b100, 8'd255, lit, bad);
        check_eq("solid255_lit_count", lit, 256);
        check_eq("solid255_shape", bad, 0);
        send(MODE_SOLID, 3'b100, 8'd0);
        wait_apply(MODE_SOLID);
        scan(3'b100, 8'd0, lit, bad);
        check_eq("solid0_lit_count", lit, 0);
        check_eq("solid0_shape", bad, 0);

        // Back-to-back: second command held off until the cycle after the wrap.
        send(MODE_SOLID, 3'b010, 8'd100);
        cmd_mode  = MODE_BLINK;
        cmd_rgb   = 3'b001;
        cmd_level = 8'd255;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 600) begin
            tick();
            n++;
        end
        check_eq("b2b_ready_after_wrap", {24'd0, pwm_m}, 32'd0);
        check_eq("b2b_first_applied", {30'd0, mode_o}, {30'd0, MODE_SOLID});
        tick();
        cmd_valid = 1'b0;
        check_eq("b2b_ready_low", {31'd0, cmd_ready}, 32'd0);
        wait_apply(MODE_BLINK);

        // BLINK at full level: 8 edges lit, 8 dark, starting lit.
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1) check_eq("blink_first_lit", {31'd0, ~blueled}, 32'd1);
            if (k == 9) check_eq("blink_first_dark", {31'd0, ~blueled}, 32'd0);
            if ((~blueled) != ((((k - 1) / 8) % 2) == 0)) bad++;
        end
        check_eq("blink_pattern", bad, 0);

        // BREATHE with peak 3: envelope steps every 2 cycles.
        send(MODE_BREATHE, 3'b111, 8'd3);
        wait_apply(MODE_BREATHE);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (int'(u_dut.w_eff) != exp_seq[c / 2]) bad++;
            tick();
        end
        check_eq("breathe_envelope", bad, 0);

        // Reset mid-breathe with a command pending discards it.
        send(MODE_SOLID, 3'b111, 8'd200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mode", {30'd0, mode_o}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_pins", {29'd0, redled, greenled, blueled}, 32'h7);
        repeat (300) tick();
        check_eq("rst_discarded_mode", {30'd0, mode_o}, 32'd0);
        check_eq("rst_discarded_pins", {29'd0, redled, greenled, blueled}, 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
